// File: rtl/mem_fill_arbiter_pkg.sv
// Shared encodings for the memory fill arbiter: FSM states, owner ids, block geometry.
package mem_fill_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_WORDS_PER_BLK = 8;
  localparam int DEF_BLK_BYTES     = 2 * DEF_WORDS_PER_BLK;

endpackage

// File: rtl/mem_fill_arbiter_fill_counter.sv
// Saturating word counter with synchronous clear/enable and a terminal-count flag.
module fill_counter #(
  parameter int W    = 4,
  parameter int TERM = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == W'(TERM));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D cache misses onto one pipelined memory, issues block reads and
// steers returning words plus a final tag write to the granted cache.
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             icache_miss,
  input  logic [ADDR_W-1:0]                icache_addr,
  input  logic                             dcache_miss,
  input  logic [ADDR_W-1:0]                dcache_addr,
  output logic                             mem_en,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_valid,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic [DATA_W-1:0]                fill_data,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_idx,
  output logic                             icache_fill_we,
  output logic                             dcache_fill_we,
  output logic                             icache_tag_we,
  output logic                             dcache_tag_we,
  output logic [ADDR_W-1:0]                fill_tag_addr,
  output logic                             busy
);

  localparam int IDX_W     = $clog2(WORDS_PER_BLK);
  localparam int CNT_W     = IDX_W + 1;
  localparam int BLK_BYTES = 2 * WORDS_PER_BLK;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLK_BYTES - 1);
  localparam int CNT_ISSUE = 0;
  localparam int CNT_RECV  = 1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_owner;
  logic [ADDR_W-1:0] r_base;

  logic              w_grant;
  logic              w_grant_owner;
  logic [ADDR_W-1:0] w_grant_base;
  logic              w_in_fill;
  logic              w_issue;
  logic              w_fire;
  logic              w_last;
  logic              w_cnt_clr;

  logic [CNT_W-1:0]  w_cnt [2];
  logic [1:0]        w_cnt_en;
  logic [1:0]        w_cnt_done;

  // D-cache wins ties: its miss belongs to the older instruction in MEM.
  always_comb begin
    w_state_next  = r_state;
    w_grant       = 1'b0;
    w_grant_owner = OWN_I;
    w_grant_base  = '0;
    case (r_state)
      ST_IDLE: begin
        if (dcache_miss) begin
          w_grant       = 1'b1;
          w_grant_owner = OWN_D;
          w_grant_base  = dcache_addr & BASE_MASK;
        end else if (icache_miss) begin
          w_grant       = 1'b1;
          w_grant_owner = OWN_I;
          w_grant_base  = icache_addr & BASE_MASK;
        end
        if (w_grant) w_state_next = ST_FILL;
      end
      ST_FILL: begin
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_I;
      r_base  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_owner <= w_grant_owner;
        r_base  <= w_grant_base;
      end
    end
  end

  assign w_in_fill = (r_state == ST_FILL);
  assign w_issue   = w_in_fill && !w_cnt_done[CNT_ISSUE];
  // Words past a full block are dropped by gating on the receive terminal count.
  assign w_fire    = w_in_fill && mem_valid && !w_cnt_done[CNT_RECV];
  assign w_last    = w_fire && (w_cnt[CNT_RECV] == CNT_W'(WORDS_PER_BLK - 1));
  assign w_cnt_clr = (r_state == ST_DONE);

  assign w_cnt_en[CNT_ISSUE] = w_issue;
  assign w_cnt_en[CNT_RECV]  = w_fire;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      fill_counter #(
        .W    (CNT_W),
        .TERM (WORDS_PER_BLK)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en[gi]),
        .o_count (w_cnt[gi]),
        .o_done  (w_cnt_done[gi])
      );
    end
  endgenerate

  assign mem_en         = w_issue;
  assign mem_addr       = w_issue ? (r_base + ADDR_W'({w_cnt[CNT_ISSUE], 1'b0})) : '0;
  assign fill_data      = w_fire ? mem_rdata : '0;
  assign fill_idx       = w_fire ? w_cnt[CNT_RECV][IDX_W-1:0] : '0;
  assign icache_fill_we = w_fire && (r_owner == OWN_I);
  assign dcache_fill_we = w_fire && (r_owner == OWN_D);
  assign icache_tag_we  = w_last && (r_owner == OWN_I);
  assign dcache_tag_we  = w_last && (r_owner == OWN_D);
  assign fill_tag_addr  = r_base;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter: latency-4 pipelined memory, per-cycle model check
// plus literal expectations on the address/index/tag logs.
module tb_mem_fill_arbiter;

  localparam int WPB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss;
  logic [15:0] icache_addr, dcache_addr;
  logic        mem_en, mem_valid;
  logic [15:0] mem_addr, mem_rdata, fill_data, fill_tag_addr;
  logic [2:0]  fill_idx;
  logic        icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we, busy;
  logic        inj_valid;

  always #5 clk = ~clk;

  mem_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(WPB)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
    .icache_tag_we(icache_tag_we), .dcache_tag_we(dcache_tag_we),
    .fill_tag_addr(fill_tag_addr), .busy(busy)
  );

  // Memory: fixed 4-cycle latency, data is a simple function of the address.
  logic [3:0]  p_v = '0;
  logic [15:0] p_d [4] = '{default: 16'h0};
  always @(posedge clk) begin
    p_v    <= {p_v[2:0], mem_en};
    p_d[0] <= mem_addr ^ 16'h5A5A;
    for (int i = 1; i < 4; i++) p_d[i] <= p_d[i-1];
  end
  assign mem_valid = p_v[3] | inj_valid;
  assign mem_rdata = p_d[3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Logs gathered from the DUT for the literal expectations.
  logic [15:0] addr_q[$];
  int          cyc_q[$];
  int          idx_q[$];
  int          cyc = 0;
  int          dtag_cyc, itag_cyc, n_tags;
  logic [15:0] dtag_addr, itag_addr;
  bit          chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: 0 idle, 1 filling, 2 one-cycle gap after the tag write.
  int          m_phase = 0;
  bit          m_own_d = 0;
  logic [15:0] m_base  = 16'h0;
  int          m_iss   = 0;
  int          m_rcv   = 0;
  bit          m_fire, m_issue;
  logic [56:0] m_exp, m_act;

  always @(negedge clk) begin
    m_issue = (m_phase == 1) && (m_iss < WPB);
    m_fire  = (m_phase == 1) && mem_valid && (m_rcv < WPB);
    m_exp = {m_issue, m_issue ? 16'(m_base + 16'(2 * m_iss)) : 16'h0,
             m_fire ? mem_rdata : 16'h0, m_fire ? 3'(m_rcv) : 3'h0,
             m_fire && !m_own_d, m_fire && m_own_d,
             m_fire && !m_own_d && (m_rcv == WPB - 1), m_fire && m_own_d && (m_rcv == WPB - 1),
             m_base, m_phase != 0};
    m_act = {mem_en, mem_addr, fill_data, fill_idx, icache_fill_we, dcache_fill_we,
             icache_tag_we, dcache_tag_we, fill_tag_addr, busy};
    if (chk_en) begin
      check("cycle_outputs", 64'(m_act), 64'(m_exp));
      if (mem_en) begin addr_q.push_back(mem_addr); cyc_q.push_back(cyc); end
      if (icache_fill_we || dcache_fill_we) idx_q.push_back(int'(fill_idx));
      if (icache_tag_we) begin itag_cyc = cyc; itag_addr = fill_tag_addr; n_tags++; end
      if (dcache_tag_we) begin dtag_cyc = cyc; dtag_addr = fill_tag_addr; n_tags++; end
      $display("cyc %0d en=%b addr=%h fwe=%b%b idx=%0d tag=%b%b busy=%b",
               cyc, mem_en, mem_addr, icache_fill_we, dcache_fill_we, fill_idx,
               icache_tag_we, dcache_tag_we, busy);
    end
    if (rst) begin
      m_phase = 0; m_own_d = 0; m_base = 16'h0; m_iss = 0; m_rcv = 0;
    end else begin
      case (m_phase)
        0: begin
          if (dcache_miss) begin
            m_own_d = 1; m_base = dcache_addr & 16'hFFF0; m_phase = 1;
          end else if (icache_miss) begin
            m_own_d = 0; m_base = icache_addr & 16'hFFF0; m_phase = 1;
          end
        end
        1: begin
          if (m_issue) m_iss++;
          if (m_fire) begin
            if (m_rcv == WPB - 1) m_phase = 2;
            m_rcv++;
          end
        end
        default: begin m_phase = 0; m_iss = 0; m_rcv = 0; end
      endcase
    end
  end

  task automatic clear_logs();
    addr_q.delete(); cyc_q.delete(); idx_q.delete();
    n_tags = 0; dtag_cyc = -1; itag_cyc = -1;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait for the owner's tag pulse, then drop that miss during the gap cycle.
  task automatic wait_tag(input bit is_d, input int budget);
    bit hit = 0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(posedge clk); #1;
      hit = is_d ? dcache_tag_we : icache_tag_we;
    end
    check(is_d ? "dtag_seen" : "itag_seen", 64'(hit), 64'd1);
    step(1);
    if (is_d) dcache_miss = 0; else icache_miss = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int zero_hits, nfill;
  bit got5;

  initial begin
    rst = 1; icache_miss = 0; dcache_miss = 0; icache_addr = 0; dcache_addr = 0; inj_valid = 0;
    clear_logs();
    step(1);
    chk_en = 1;
    step(2);
    rst = 0;
    check("reset_outputs", 64'({mem_en, mem_addr, fill_data, fill_idx, icache_fill_we, dcache_fill_we,
                                icache_tag_we, dcache_tag_we, fill_tag_addr, busy}), 64'd0);

    // I-miss only
    clear_logs();
    icache_addr = 16'h1236; icache_miss = 1;
    wait_tag(0, 40);
    check("s1_count", addr_q.size(), 8);
    for (int k = 0; k < 8 && k < addr_q.size(); k++) begin
      check("s1_addr", addr_q[k], 64'(16'h1230 + 2 * k));
      check("s1_consecutive", cyc_q[k] - cyc_q[0], k);
    end
    for (int k = 0; k < 8 && k < idx_q.size(); k++) check("s1_idx", idx_q[k], k);
    check("s1_idx_count", idx_q.size(), 8);
    check("s1_tag_addr", itag_addr, 16'h1230);
    step(2);

    // Simultaneous D and I misses: D first, single gap, then I
    clear_logs();
    dcache_addr = 16'h0042; icache_addr = 16'h2000;
    dcache_miss = 1; icache_miss = 1;
    wait_tag(1, 40);
    wait_tag(0, 40);
    check("s2_count", addr_q.size(), 16);
    if (addr_q.size() >= 16) begin
      check("s2_d_first", addr_q[0], 16'h0040);
      check("s2_i_second", addr_q[8], 16'h2000);
      check("s2_gap", cyc_q[8] - dtag_cyc, 3);
    end
    check("s2_dtag_addr", dtag_addr, 16'h0040);
    check("s2_itag_addr", itag_addr, 16'h2000);
    step(2);

    // I-miss arriving mid D fill waits for the D tag write
    clear_logs();
    dcache_addr = 16'h0300; dcache_miss = 1;
    step(4);
    icache_addr = 16'h0100; icache_miss = 1;
    wait_tag(1, 40);
    wait_tag(0, 40);
    check("s3_count", addr_q.size(), 16);
    if (addr_q.size() >= 16) begin
      check("s3_d_last", addr_q[7], 16'h030E);
      check("s3_i_first", addr_q[8], 16'h0100);
      check("s3_i_after_dtag", 64'(cyc_q[8] > dtag_cyc), 64'd1);
    end
    step(2);

    // Reset mid-fill aborts; late returns ignored; retry restarts at word 0
    clear_logs();
    icache_addr = 16'h0500; icache_miss = 1;
    got5 = 0;
    for (int n = 0; n < 40 && !got5; n++) begin
      @(negedge clk);
      got5 = (idx_q.size() >= 5);
    end
    check("s4_five_words", 64'(got5), 64'd1);
    @(posedge clk); #1;
    rst = 1; icache_miss = 0;
    step(1);
    rst = 0;
    check("s4_post_reset", 64'({mem_en, mem_addr, fill_idx, icache_fill_we, dcache_fill_we,
                                icache_tag_we, dcache_tag_we, fill_tag_addr, busy}), 64'd0);
    check("s4_no_tag", n_tags, 0);
    nfill = idx_q.size();
    step(10);
    check("s4_late_ignored", idx_q.size(), nfill);
    clear_logs();
    icache_miss = 1;
    wait_tag(0, 40);
    check("s4_retry_count", idx_q.size(), 8);
    if (idx_q.size() > 0) check("s4_retry_idx0", idx_q[0], 0);
    if (addr_q.size() > 0) check("s4_retry_addr0", addr_q[0], 16'h0500);
    step(2);

    // Top-of-memory block: no wrap to 0x0000
    clear_logs();
    dcache_addr = 16'hFFFF; dcache_miss = 1;
    wait_tag(1, 40);
    check("s5_count", addr_q.size(), 8);
    if (addr_q.size() >= 8) begin
      check("s5_first", addr_q[0], 16'hFFF0);
      check("s5_last", addr_q[7], 16'hFFFE);
    end
    zero_hits = 0;
    foreach (addr_q[k]) if (addr_q[k] == 16'h0000) zero_hits++;
    check("s5_no_wrap", zero_hits, 0);
    check("s5_tag_addr", dtag_addr, 16'hFFF0);
    step(2);

    // Spurious mem_valid while idle
    clear_logs();
    inj_valid = 1;
    step(1);
    check("s6_idle_fwe", 64'({icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we}), 64'd0);
    step(2);
    inj_valid = 0;
    step(2);
    check("s6_no_fill", idx_q.size(), 0);
    check("s6_no_tag", n_tags, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
